// File: rtl/game_pkg.sv
// Shared types and defaults for the pong game-flow controller.
package game_pkg;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StWaitServe = 2'd1,
        StPlay      = 2'd2,
        StGameOver  = 2'd3
    } game_state_t;

    localparam logic [1:0] WinnerNone = 2'd0;
    localparam logic [1:0] WinnerP1   = 2'd1;
    localparam logic [1:0] WinnerP2   = 2'd2;

    localparam int unsigned DefWinPoints    = 11;
    localparam int unsigned DefOverFrames   = 180;
    localparam int unsigned DefServeTimeout = 300;

    localparam int unsigned FrameCntW = 9;

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchroniser for a raw button followed by a rising-edge detector that yields a
// one-cycle press pulse.
module btn_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 2'b00;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            prev_q <= sync_q[1];
        end
    end

    assign press_o = sync_q[1] & ~prev_q;

endmodule

// File: rtl/game_state_ctl.sv
// Game-flow controller: mode selection, serve requests and end-of-match detection for
// ball_control. Optional automatic serve after a frame timeout: define GAME_AUTO_SERVE_EN.
module game_state_ctl
    import game_pkg::*;
#(
    parameter int unsigned WIN_POINTS    = DefWinPoints,
    parameter int unsigned OVER_FRAMES   = DefOverFrames,
    parameter int unsigned SERVE_TIMEOUT = DefServeTimeout
) (
    input  logic       clk65MHz,
    input  logic       rst,
    input  logic       end_of_frame,
    input  logic       btn_single,
    input  logic       btn_multi,
    input  logic       btn_serve,
    input  logic [3:0] points_player_1,
    input  logic [3:0] points_player_2,
    output logic       screen_idle,
    output logic       screen_multi,
    output logic       serve,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam logic [3:0]           WinScore    = 4'(WIN_POINTS);
    localparam logic [FrameCntW-1:0] FrameCntMax = '1;

    game_state_t          state_q, state_d;
    logic                 mode_q, mode_d;
    logic [1:0]           winner_q, winner_d;
    logic                 serve_pending_q, serve_pending_d;
    logic                 serve_q, serve_d;
    logic                 screen_idle_q, game_over_q;
    logic [FrameCntW-1:0] frame_cnt_q, frame_cnt_d;
    logic [3:0]           p1_q, p2_q;

    logic press_single, press_multi, press_serve;
    logic p1_win, p2_win, point_evt;
    logic [FrameCntW:0] frame_limit;
    logic frame_done, auto_serve;

    btn_edge u_edge_single (
        .clk_i   (clk65MHz),
        .rst_i   (rst),
        .btn_i   (btn_single),
        .press_o (press_single)
    );

    btn_edge u_edge_multi (
        .clk_i   (clk65MHz),
        .rst_i   (rst),
        .btn_i   (btn_multi),
        .press_o (press_multi)
    );

    btn_edge u_edge_serve (
        .clk_i   (clk65MHz),
        .rst_i   (rst),
        .btn_i   (btn_serve),
        .press_o (press_serve)
    );

    // Only an increase can end the match; a drop means ball_control was reset.
    assign p1_win    = (points_player_1 > p1_q) && (points_player_1 >= WinScore);
    assign p2_win    = (points_player_2 > p2_q) && (points_player_2 >= WinScore);
    assign point_evt = (points_player_1 != p1_q) || (points_player_2 != p2_q);

    // One frame counter serves both the game-over hold and the serve timeout.
    assign frame_limit = (state_q == StGameOver) ? (FrameCntW + 1)'(OVER_FRAMES)
                                                 : (FrameCntW + 1)'(SERVE_TIMEOUT);
    assign frame_done  = end_of_frame && (({1'b0, frame_cnt_q} + 1'b1) >= frame_limit);

`ifdef GAME_AUTO_SERVE_EN
    assign auto_serve = frame_done;
`else
    assign auto_serve = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        mode_d          = mode_q;
        winner_d        = winner_q;
        serve_pending_d = serve_pending_q;
        frame_cnt_d     = frame_cnt_q;

        if (end_of_frame && (frame_cnt_q != FrameCntMax)) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
        // An end_of_frame only releases the serve once serve is visibly high.
        if (serve_q && end_of_frame) begin
            serve_pending_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (press_single) begin
                    state_d = StWaitServe;
                    mode_d  = 1'b0;
                end else if (press_multi) begin
                    state_d = StWaitServe;
                    mode_d  = 1'b1;
                end
            end
            StWaitServe: begin
                if (press_serve || auto_serve) begin
                    state_d         = StPlay;
                    serve_pending_d = 1'b1;
                end
            end
            StPlay: begin
                if (p1_win) begin
                    state_d  = StGameOver;
                    winner_d = WinnerP1;
                end else if (p2_win) begin
                    state_d  = StGameOver;
                    winner_d = WinnerP2;
                end else if (point_evt) begin
                    state_d = StWaitServe;
                end
            end
            StGameOver: begin
                if (frame_done) begin
                    state_d  = StIdle;
                    winner_d = WinnerNone;
                    mode_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            frame_cnt_d = '0;
        end
    end

    assign serve_d = serve_pending_q && !(serve_q && end_of_frame);

    always_ff @(posedge clk65MHz) begin
        if (rst) begin
            state_q         <= StIdle;
            mode_q          <= 1'b0;
            winner_q        <= WinnerNone;
            serve_pending_q <= 1'b0;
            serve_q         <= 1'b0;
            screen_idle_q   <= 1'b1;
            game_over_q     <= 1'b0;
            frame_cnt_q     <= '0;
            p1_q            <= 4'd0;
            p2_q            <= 4'd0;
        end else begin
            state_q         <= state_d;
            mode_q          <= mode_d;
            winner_q        <= winner_d;
            serve_pending_q <= serve_pending_d;
            serve_q         <= serve_d;
            screen_idle_q   <= (state_d == StIdle) || (state_d == StGameOver);
            game_over_q     <= (state_d == StGameOver);
            frame_cnt_q     <= frame_cnt_d;
            p1_q            <= points_player_1;
            p2_q            <= points_player_2;
        end
    end

    assign screen_idle  = screen_idle_q;
    assign screen_multi = mode_q;
    assign serve        = serve_q;
    assign game_over    = game_over_q;
    assign winner       = winner_q;

endmodule

// File: tb/tb_game_state_ctl.sv
// Directed bench for game_state_ctl: mode select, serve timing, scoring, game-over hold, reset.
module tb_game_state_ctl;
    import game_pkg::*;

    logic       clk65MHz;
    logic       rst;
    logic       end_of_frame;
    logic       btn_single;
    logic       btn_multi;
    logic       btn_serve;
    logic [3:0] points_player_1;
    logic [3:0] points_player_2;
    logic       screen_idle;
    logic       screen_multi;
    logic       serve;
    logic       game_over;
    logic [1:0] winner;

    int n_checks = 0;
    int n_fail   = 0;

    game_state_ctl #(
        .WIN_POINTS    (11),
        .OVER_FRAMES   (180),
        .SERVE_TIMEOUT (5)
    ) dut (
        .clk65MHz        (clk65MHz),
        .rst             (rst),
        .end_of_frame    (end_of_frame),
        .btn_single      (btn_single),
        .btn_multi       (btn_multi),
        .btn_serve       (btn_serve),
        .points_player_1 (points_player_1),
        .points_player_2 (points_player_2),
        .screen_idle     (screen_idle),
        .screen_multi    (screen_multi),
        .serve           (serve),
        .game_over       (game_over),
        .winner          (winner)
    );

    initial clk65MHz = 1'b0;
    always #5 clk65MHz = ~clk65MHz;

    task automatic tick();
        @(posedge clk65MHz);
        #1;
    endtask

    task automatic frame_pulse();
        end_of_frame = 1'b1;
        tick();
        end_of_frame = 1'b0;
        tick();
    endtask

    // From WAIT_SERVE: press serve, let serve rise, then release it with one frame.
    task automatic do_serve();
        btn_serve = 1'b1;
        tick();
        btn_serve = 1'b0;
        repeat (3) tick();
        frame_pulse();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        n_checks++; if (dut.state_q !== StIdle) begin n_fail++;
            $display("FAIL rst_state: got %0d want %0d", dut.state_q, StIdle); end
        n_checks++; if (screen_idle !== 1'b1) begin n_fail++;
            $display("FAIL rst_screen_idle: got %b want 1", screen_idle); end
        n_checks++; if ({screen_multi, serve, game_over, winner} !== 5'b0) begin n_fail++;
            $display("FAIL rst_outputs: multi/serve/over/winner=%b%b%b%b want 00000",
                     screen_multi, serve, game_over, winner); end
        rst = 1'b0;
    endtask

    task automatic test_mode_select();
        btn_multi = 1'b1;
        tick();
        btn_multi = 1'b0;
        tick();
        n_checks++; if (dut.state_q !== StIdle) begin n_fail++;
            $display("FAIL multi_latency_early: got %0d want %0d", dut.state_q, StIdle); end
        tick();
        n_checks++; if (dut.state_q !== StWaitServe) begin n_fail++;
            $display("FAIL multi_state: got %0d want %0d", dut.state_q, StWaitServe); end
        n_checks++; if (screen_idle !== 1'b0 || screen_multi !== 1'b1) begin n_fail++;
            $display("FAIL multi_screen: idle=%b multi=%b want 0 1", screen_idle,
                     screen_multi); end
    endtask

    task automatic test_serve();
        btn_serve = 1'b1;
        tick();
        btn_serve = 1'b0;
        repeat (2) tick();
        n_checks++; if (dut.state_q !== StPlay || serve !== 1'b0) begin n_fail++;
            $display("FAIL serve_n3: state=%0d serve=%b want %0d 0", dut.state_q, serve,
                     StPlay); end
        tick();
        n_checks++; if (serve !== 1'b1) begin n_fail++;
            $display("FAIL serve_rise: got %b want 1", serve); end
        repeat (2) tick();
        end_of_frame = 1'b1;
        n_checks++; if (serve !== 1'b1) begin n_fail++;
            $display("FAIL serve_hold_eof: got %b want 1", serve); end
        tick();
        end_of_frame = 1'b0;
        n_checks++; if (serve !== 1'b0) begin n_fail++;
            $display("FAIL serve_clear: got %b want 0", serve); end
        btn_serve = 1'b1;
        tick();
        btn_serve = 1'b0;
        repeat (5) tick();
        n_checks++; if (serve !== 1'b0 || dut.state_q !== StPlay) begin n_fail++;
            $display("FAIL serve_ignored_in_play: serve=%b state=%0d want 0 %0d", serve,
                     dut.state_q, StPlay); end
    endtask

    task automatic test_point_event();
        points_player_2 = 4'd3;
        tick();
        n_checks++; if (dut.state_q !== StWaitServe) begin n_fail++;
            $display("FAIL point_0_3: got %0d want %0d", dut.state_q, StWaitServe); end
        do_serve();
        points_player_2 = 4'd4;
        n_checks++; if (dut.state_q !== StPlay) begin n_fail++;
            $display("FAIL point_pre_edge: got %0d want %0d", dut.state_q, StPlay); end
        tick();
        n_checks++; if (dut.state_q !== StWaitServe || winner !== 2'd0) begin n_fail++;
            $display("FAIL point_3_4: state=%0d winner=%0d want %0d 0", dut.state_q, winner,
                     StWaitServe); end
        points_player_1 = 4'd10;
        tick();
        do_serve();
        points_player_1 = 4'd11;
        tick();
        n_checks++; if (dut.state_q !== StGameOver || winner !== 2'd1) begin n_fail++;
            $display("FAIL win_p1: state=%0d winner=%0d want %0d 1", dut.state_q, winner,
                     StGameOver); end
        n_checks++; if (screen_idle !== 1'b1 || game_over !== 1'b1 || screen_multi !== 1'b1)
        begin n_fail++;
            $display("FAIL win_p1_outputs: idle=%b over=%b multi=%b want 1 1 1", screen_idle,
                     game_over, screen_multi); end
    endtask

    task automatic test_game_over_hold();
        btn_single = 1'b1;
        tick();
        btn_single = 1'b0;
        repeat (179) frame_pulse();
        n_checks++; if (dut.state_q !== StGameOver || winner !== 2'd1) begin n_fail++;
            $display("FAIL over_179: state=%0d winner=%0d want %0d 1", dut.state_q, winner,
                     StGameOver); end
        frame_pulse();
        n_checks++; if (dut.state_q !== StIdle || winner !== 2'd0) begin n_fail++;
            $display("FAIL over_180: state=%0d winner=%0d want %0d 0", dut.state_q, winner,
                     StIdle); end
        n_checks++; if (screen_multi !== 1'b0 || screen_idle !== 1'b1 || game_over !== 1'b0)
        begin n_fail++;
            $display("FAIL over_exit_outputs: multi=%b idle=%b over=%b want 0 1 0",
                     screen_multi, screen_idle, game_over); end
    endtask

    task automatic test_both_buttons();
        btn_single = 1'b1;
        btn_multi  = 1'b1;
        tick();
        btn_single = 1'b0;
        btn_multi  = 1'b0;
        repeat (2) tick();
        n_checks++; if (dut.state_q !== StWaitServe || screen_multi !== 1'b0) begin n_fail++;
            $display("FAIL both_buttons: state=%0d multi=%b want %0d 0", dut.state_q,
                     screen_multi, StWaitServe); end
    endtask

    task automatic test_eof_with_press();
        btn_serve = 1'b1;
        tick();
        btn_serve = 1'b0;
        tick();
        end_of_frame = 1'b1;
        tick();
        n_checks++; if (dut.state_q !== StPlay || serve !== 1'b0) begin n_fail++;
            $display("FAIL eof_press_n3: state=%0d serve=%b want %0d 0", dut.state_q, serve,
                     StPlay); end
        tick();
        end_of_frame = 1'b0;
        repeat (2) tick();
        n_checks++; if (serve !== 1'b1) begin n_fail++;
            $display("FAIL eof_press_held: got %b want 1", serve); end
        end_of_frame = 1'b1;
        tick();
        end_of_frame = 1'b0;
        n_checks++; if (serve !== 1'b0) begin n_fail++;
            $display("FAIL eof_press_clear: got %b want 0", serve); end
    endtask

    task automatic test_score_decrease();
        points_player_1 = 4'd0;
        tick();
        n_checks++; if (dut.state_q !== StWaitServe || game_over !== 1'b0) begin n_fail++;
            $display("FAIL dec_11_0: state=%0d over=%b want %0d 0", dut.state_q, game_over,
                     StWaitServe); end
        points_player_1 = 4'd15;
        tick();
        do_serve();
        points_player_1 = 4'd12;
        tick();
        n_checks++; if (dut.state_q !== StWaitServe || game_over !== 1'b0) begin n_fail++;
            $display("FAIL dec_15_12: state=%0d over=%b want %0d 0", dut.state_q, game_over,
                     StWaitServe); end
    endtask

    task automatic test_simultaneous_points();
        points_player_1 = 4'd10;
        points_player_2 = 4'd10;
        tick();
        do_serve();
        points_player_1 = 4'd11;
        points_player_2 = 4'd11;
        tick();
        n_checks++; if (dut.state_q !== StGameOver || winner !== 2'd1) begin n_fail++;
            $display("FAIL both_score: state=%0d winner=%0d want %0d 1", dut.state_q, winner,
                     StGameOver); end
    endtask

    task automatic test_reset_mid();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (dut.state_q !== StIdle || winner !== 2'd0 || game_over !== 1'b0)
        begin n_fail++;
            $display("FAIL rst_from_over: state=%0d winner=%0d over=%b want %0d 0 0",
                     dut.state_q, winner, game_over, StIdle); end
        btn_multi = 1'b1;
        tick();
        btn_multi = 1'b0;
        repeat (2) tick();
        points_player_1 = 4'd3;
        points_player_2 = 4'd10;
        tick();
        do_serve();
        points_player_2 = 4'd11;
        tick();
        n_checks++; if (dut.state_q !== StGameOver || winner !== 2'd2) begin n_fail++;
            $display("FAIL win_p2: state=%0d winner=%0d want %0d 2", dut.state_q, winner,
                     StGameOver); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        btn_single = 1'b1;
        tick();
        btn_single = 1'b0;
        repeat (2) tick();
        btn_serve = 1'b1;
        tick();
        btn_serve = 1'b0;
        repeat (3) tick();
        n_checks++; if (serve !== 1'b1) begin n_fail++;
            $display("FAIL rst_pre_serve: got %b want 1", serve); end
        rst = 1'b1;
        tick();
        n_checks++; if (dut.state_q !== StIdle || serve !== 1'b0 || screen_idle !== 1'b1)
        begin n_fail++;
            $display("FAIL rst_mid_play: state=%0d serve=%b idle=%b want %0d 0 1",
                     dut.state_q, serve, screen_idle, StIdle); end
        rst = 1'b0;
        repeat (3) tick();
        n_checks++; if (serve !== 1'b0) begin n_fail++;
            $display("FAIL rst_drops_serve: got %b want 0", serve); end
    endtask

    task automatic test_wait_serve_timeout();
        btn_single = 1'b1;
        tick();
        btn_single = 1'b0;
        repeat (2) tick();
`ifdef GAME_AUTO_SERVE_EN
        repeat (4) frame_pulse();
        n_checks++; if (dut.state_q !== StWaitServe || serve !== 1'b0) begin n_fail++;
            $display("FAIL auto_before: state=%0d serve=%b want %0d 0", dut.state_q, serve,
                     StWaitServe); end
        end_of_frame = 1'b1;
        tick();
        end_of_frame = 1'b0;
        n_checks++; if (dut.state_q !== StPlay) begin n_fail++;
            $display("FAIL auto_state: got %0d want %0d", dut.state_q, StPlay); end
        tick();
        n_checks++; if (serve !== 1'b1) begin n_fail++;
            $display("FAIL auto_serve: got %b want 1", serve); end
`else
        repeat (6) frame_pulse();
        n_checks++; if (dut.state_q !== StWaitServe || serve !== 1'b0) begin n_fail++;
            $display("FAIL wait_forever: state=%0d serve=%b want %0d 0", dut.state_q, serve,
                     StWaitServe); end
`endif
    endtask

    initial begin
        rst             = 1'b1;
        end_of_frame    = 1'b0;
        btn_single      = 1'b0;
        btn_multi       = 1'b0;
        btn_serve       = 1'b0;
        points_player_1 = 4'd0;
        points_player_2 = 4'd0;
        test_reset();
        test_mode_select();
        test_serve();
        test_point_event();
        test_game_over_hold();
        test_both_buttons();
        test_eof_with_press();
        test_score_decrease();
        test_simultaneous_points();
        test_reset_mid();
        test_wait_serve_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
